vga_io_adapter: RTL and testbench

- Parametrised pad-side I/O stage between the pong core and the Tiny Tapeout pins. It supersedes the fixed, purely combinational pin assignment.
- Input side: synchronises and debounces N player buttons, and emits press pulses.
- Output side: registers VGA sync and colour. Two pin maps: 2-bit-per-channel TinyVGA PMOD with optional spatio-temporal Bayer dithering, or parallel RGB444. The mode changes only at frame boundaries.

---
 rtl/vga_io_pkg.sv | 46 ++++
 rtl/vga_io_adapter_btn_debounce.sv | 53 +++++
 rtl/vga_io_adapter.sv | 126 ++++++++++++
 tb/tb_vga_io_adapter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_io_pkg.sv
// Shared definitions for the pad-side VGA/button I/O stage: mode encoding,
// Bayer dither matrix, pin maps and the dither quantiser.
package vga_io_pkg;

    typedef enum logic {
        MODE_TINYVGA = 1'b0,
        MODE_RGB444  = 1'b1
    } mode_e;

    // Indexed [y_lsb][x_lsb]
    localparam logic [1:0] BAYER [0:1][0:1] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

    // TinyVGA PMOD map on uo_out
    localparam int unsigned TV_R1 = 0;
    localparam int unsigned TV_G1 = 1;
    localparam int unsigned TV_B1 = 2;
    localparam int unsigned TV_VS = 3;
    localparam int unsigned TV_R0 = 4;
    localparam int unsigned TV_G0 = 5;
    localparam int unsigned TV_B0 = 6;
    localparam int unsigned TV_HS = 7;

    // RGB444 map: R4/G4 nibbles on uo_out, B4 and syncs on uio_out
    localparam int unsigned RGB_R_LSB  = 4;
    localparam int unsigned RGB_G_LSB  = 0;
    localparam int unsigned RGB_B_LSB  = 4;
    localparam int unsigned RGB_HS     = 3;
    localparam int unsigned RGB_VS     = 2;

    function automatic logic [1:0] dither_quant(
        input logic [1:0] q,
        input logic [1:0] f,
        input logic [1:0] frame_cnt,
        input logic       x_lsb,
        input logic       y_lsb,
        input logic       en
    );
        logic [1:0] t;
        t = BAYER[y_lsb][x_lsb] + frame_cnt;  // 2-bit add wraps mod 4
        if (en && (f > t) && (q != 2'd3)) begin
            return q + 2'd1;
        end
        return q;
    endfunction

endpackage

// File: rtl/vga_io_adapter_btn_debounce.sv
// Single-button synchroniser, stability-counter debouncer and press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d = db_d & ~db_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            db_q    <= db_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db    = db_q;
    assign btn_press = press_q;

endmodule

// File: rtl/vga_io_adapter.sv
// Pad-side I/O stage: debounced buttons in, registered VGA pins out with
// TinyVGA (optionally dithered) or RGB444 maps switched at frame boundaries.
module vga_io_adapter
    import vga_io_pkg::*;
#(
    parameter int unsigned NUM_BTNS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned COLOR_BITS      = 4,
    parameter logic        SYNC_IDLE       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  dither_en,
    input  logic [NUM_BTNS-1:0]   btn_raw,
    output logic [NUM_BTNS-1:0]   btn_db,
    output logic [NUM_BTNS-1:0]   btn_press,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [COLOR_BITS-1:0] r_in,
    input  logic [COLOR_BITS-1:0] g_in,
    input  logic [COLOR_BITS-1:0] b_in,
    input  logic                  x_lsb,
    input  logic                  y_lsb,
    output logic [7:0]            uo_out,
    output logic [7:0]            uio_out,
    output logic [7:0]            uio_oe
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk      (clk),
            .rst      (rst),
            .btn_raw  (btn_raw[i]),
            .btn_db   (btn_db[i]),
            .btn_press(btn_press[i])
        );
    end

    mode_e      mode_act_q, mode_act_d, mode_sel;
    logic       vs_prev_q;
    logic       frame_edge;
    logic [1:0] frame_cnt_q, frame_cnt_d;
    logic       hs_sel, vs_sel;
    logic [1:0] r2, g2, b2;
    logic [3:0] r4, g4, b4;
    logic [7:0] uo_d, uo_q, uio_d, uio_q, oe_d, oe_q;

    always_comb begin
        frame_edge  = vs_prev_q & ~vsync_in;
        mode_act_d  = mode_act_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_edge) begin
            mode_act_d  = mode_e'(mode);
            frame_cnt_d = frame_cnt_q + 2'd1;
        end
    end

    // Pins follow mode_act_d so the map flips on the same edge as mode_act_q;
    // during reset they load the idle pattern for the incoming mode.
    always_comb begin
        mode_sel = rst ? mode_e'(mode) : mode_act_d;
        hs_sel   = rst ? SYNC_IDLE : hsync_in;
        vs_sel   = rst ? SYNC_IDLE : vsync_in;
        r2 = '0;
        g2 = '0;
        b2 = '0;
        r4 = '0;
        g4 = '0;
        b4 = '0;
        if (!rst) begin
            r2 = dither_quant(r_in[COLOR_BITS-1 -: 2], r_in[COLOR_BITS-3 -: 2],
                              frame_cnt_q, x_lsb, y_lsb, dither_en);
            g2 = dither_quant(g_in[COLOR_BITS-1 -: 2], g_in[COLOR_BITS-3 -: 2],
                              frame_cnt_q, x_lsb, y_lsb, dither_en);
            b2 = dither_quant(b_in[COLOR_BITS-1 -: 2], b_in[COLOR_BITS-3 -: 2],
                              frame_cnt_q, x_lsb, y_lsb, dither_en);
            r4 = r_in[COLOR_BITS-1 -: 4];
            g4 = g_in[COLOR_BITS-1 -: 4];
            b4 = b_in[COLOR_BITS-1 -: 4];
        end

        uo_d  = '0;
        uio_d = '0;
        oe_d  = '0;
        if (mode_sel == MODE_TINYVGA) begin
            uo_d[TV_HS] = hs_sel;
            uo_d[TV_B0] = b2[0];
            uo_d[TV_G0] = g2[0];
            uo_d[TV_R0] = r2[0];
            uo_d[TV_VS] = vs_sel;
            uo_d[TV_B1] = b2[1];
            uo_d[TV_G1] = g2[1];
            uo_d[TV_R1] = r2[1];
        end else begin
            uo_d[RGB_R_LSB +: 4]  = r4;
            uo_d[RGB_G_LSB +: 4]  = g4;
            uio_d[RGB_B_LSB +: 4] = b4;
            uio_d[RGB_HS]         = hs_sel;
            uio_d[RGB_VS]         = vs_sel;
            oe_d                  = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q   <= 1'b0;
            frame_cnt_q <= '0;
            mode_act_q  <= mode_e'(mode);
        end else begin
            vs_prev_q   <= vsync_in;
            frame_cnt_q <= frame_cnt_d;
            mode_act_q  <= mode_act_d;
        end
        uo_q  <= uo_d;
        uio_q <= uio_d;
        oe_q  <= oe_d;
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = oe_q;

endmodule

// File: tb/tb_vga_io_adapter.sv
// Self-checking bench for vga_io_adapter: directed scenarios plus randomized
// traffic against a sliding-window / arithmetic reference model.
module tb_vga_io_adapter;

    localparam int NB = 4;
    localparam int DC = 4;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          dither_en = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_db, btn_press;
    logic          hsync_in = 1'b1;
    logic          vsync_in = 1'b1;
    logic [CB-1:0] r_in = '0, g_in = '0, b_in = '0;
    logic          x_lsb = 1'b0, y_lsb = 1'b0;
    logic [7:0]    uo_out, uio_out, uio_oe;

    int checks = 0;
    int failures = 0;

    vga_io_adapter #(
        .NUM_BTNS       (NB),
        .DEBOUNCE_CYCLES(DC),
        .COLOR_BITS     (CB),
        .SYNC_IDLE      (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .dither_en(dither_en),
        .btn_raw  (btn_raw),
        .btn_db   (btn_db),
        .btn_press(btn_press),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .r_in     (r_in),
        .g_in     (g_in),
        .b_in     (b_in),
        .x_lsb    (x_lsb),
        .y_lsb    (y_lsb),
        .uo_out   (uo_out),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned bay[4] = '{0, 2, 3, 1};  // Bayer value at index y*2+x
    bit          mode_m;
    int unsigned fc_m;
    bit          vsp_m;
    bit          bnd_m;
    bit          all_diff;
    bit [DC:0]   sh [NB];
    bit [NB-1:0] db_m, press_m;
    logic [7:0]  exp_uo, exp_uio, exp_oe;

    function automatic int unsigned lvl(input int unsigned v, input int unsigned x,
                                        input int unsigned y, input int unsigned fc,
                                        input bit den);
        int unsigned l = v / 4;
        int unsigned t = (bay[y * 2 + x] + fc) % 4;
        if (den && (v % 4) > t && l < 3) l++;
        return l;
    endfunction

    task automatic calc_pins(input bit m, input bit hs, input bit vs,
                             input int unsigned r, input int unsigned g, input int unsigned b,
                             input int unsigned x, input int unsigned y, input int unsigned fc,
                             input bit den,
                             output logic [7:0] uo, output logic [7:0] uio, output logic [7:0] oe);
        int unsigned rl, gl, bl;
        if (m) begin
            uo  = 8'(r * 16 + g);
            uio = 8'(b * 16 + int'(hs) * 8 + int'(vs) * 4);
            oe  = 8'hFF;
        end else begin
            rl  = lvl(r, x, y, fc, den);
            gl  = lvl(g, x, y, fc, den);
            bl  = lvl(b, x, y, fc, den);
            uo  = 8'(int'(hs) * 128 + (bl % 2) * 64 + (gl % 2) * 32 + (rl % 2) * 16
                     + int'(vs) * 8 + (bl / 2) * 4 + (gl / 2) * 2 + (rl / 2));
            uio = 8'h00;
            oe  = 8'h00;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mode_m  = mode;
            fc_m    = 0;
            vsp_m   = 1'b0;
            calc_pins(mode, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0, exp_uo, exp_uio, exp_oe);
            db_m    = '0;
            press_m = '0;
            for (int b = 0; b < NB; b++) sh[b] = '0;
        end else begin
            bnd_m = vsp_m && !vsync_in;
            if (bnd_m) mode_m = mode;
            calc_pins(mode_m, hsync_in, vsync_in, r_in, g_in, b_in, x_lsb, y_lsb, fc_m,
                      dither_en, exp_uo, exp_uio, exp_oe);
            if (bnd_m) fc_m = (fc_m + 1) % 4;
            vsp_m = vsync_in;
            // db flips once the synchronised samples (delayed 2) were all opposite for DC cycles
            for (int b = 0; b < NB; b++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DC; k++) if (sh[b][k] == db_m[b]) all_diff = 1'b0;
                press_m[b] = 1'b0;
                if (all_diff) begin
                    db_m[b]    = ~db_m[b];
                    press_m[b] = db_m[b];
                end
                sh[b] = {sh[b][DC-1:0], btn_raw[b]};
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        btn_raw   = '0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        r_in      = '0;
        g_in      = '0;
        b_in      = '0;
        x_lsb     = 1'b0;
        y_lsb     = 1'b0;
        dither_en = 1'b0;
    endtask

    task automatic reset_dut(input bit m);
        @(negedge clk);
        rst  = 1'b1;
        mode = m;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] e_uo, e_uio, e_oe;
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            rst  = 1'b1;
            mode = 1'(m);
            idle_inputs();
            @(negedge clk);
            e_uo  = (m == 0) ? 8'h88 : 8'h00;
            e_uio = (m == 0) ? 8'h00 : 8'h0C;
            e_oe  = (m == 0) ? 8'h00 : 8'hFF;
            checks++; if (uo_out !== e_uo) begin failures++; $display("FAIL reset_uo mode=%0d got=%h exp=%h", m, uo_out, e_uo); end
            checks++; if (uio_out !== e_uio) begin failures++; $display("FAIL reset_uio mode=%0d got=%h exp=%h", m, uio_out, e_uio); end
            checks++; if (uio_oe !== e_oe) begin failures++; $display("FAIL reset_oe mode=%0d got=%h exp=%h", m, uio_oe, e_oe); end
            checks++; if (btn_db !== 4'b0000) begin failures++; $display("FAIL reset_btn_db got=%b exp=0000", btn_db); end
            checks++; if (btn_press !== 4'b0000) begin failures++; $display("FAIL reset_btn_press got=%b exp=0000", btn_press); end
        end
        rst = 1'b0;
    endtask

    task automatic test_debounce();
        logic [NB-1:0] e_db, e_pr;
        reset_dut(1'b0);
        btn_raw = 4'b0100;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            e_db = (i >= DC + 1) ? 4'b0100 : 4'b0000;
            e_pr = (i == DC + 1) ? 4'b0100 : 4'b0000;
            checks++; if (btn_db !== e_db) begin failures++; $display("FAIL db_latency edge=%0d got=%b exp=%b", i, btn_db, e_db); end
            checks++; if (btn_press !== e_pr) begin failures++; $display("FAIL press_pulse edge=%0d got=%b exp=%b", i, btn_press, e_pr); end
        end
        // 3-cycle glitch on bit 2 (low) and bit 1 (high): no change expected
        btn_raw = 4'b0010;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) btn_raw = 4'b0100;
            @(negedge clk);
            checks++; if (btn_db !== 4'b0100) begin failures++; $display("FAIL glitch_db cyc=%0d got=%b exp=0100", i, btn_db); end
            checks++; if (btn_press !== 4'b0000) begin failures++; $display("FAIL glitch_press cyc=%0d got=%b exp=0000", i, btn_press); end
        end
    endtask

    task automatic test_random_buttons();
        reset_dut(1'b0);
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                rst = 1'b1;  // reset in the middle of debouncing
            end else begin
                rst = 1'b0;
            end
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 5) == 0) btn_raw[b] = ~btn_raw[b];
            @(negedge clk);
            checks++; if (btn_db !== db_m) begin failures++; $display("FAIL rand_btn_db cyc=%0d got=%b exp=%b", i, btn_db, db_m); end
            checks++; if (btn_press !== press_m) begin failures++; $display("FAIL rand_btn_press cyc=%0d got=%b exp=%b", i, btn_press, press_m); end
        end
        rst = 1'b0;
    endtask

    task automatic vsync_fall();
        vsync_in = 1'b0;
        @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dither();
        reset_dut(1'b0);
        r_in = 4'hB;
        @(negedge clk);
        checks++; if (uo_out !== 8'h89) begin failures++; $display("FAIL trunc_B got=%h exp=89", uo_out); end
        dither_en = 1'b1;
        @(negedge clk);
        checks++; if (uo_out !== 8'h99) begin failures++; $display("FAIL dither_B got=%h exp=99", uo_out); end
        r_in = 4'hF;
        @(negedge clk);
        checks++; if (uo_out !== 8'h99) begin failures++; $display("FAIL dither_sat got=%h exp=99", uo_out); end
        r_in  = 4'h5;
        x_lsb = 1'b1;
        @(negedge clk);
        checks++; if (uo_out !== 8'h98) begin failures++; $display("FAIL dither_fc0 got=%h exp=98", uo_out); end
        vsync_fall();
        @(negedge clk);
        checks++; if (uo_out !== 8'h98) begin failures++; $display("FAIL dither_fc1 got=%h exp=98", uo_out); end
        vsync_fall();
        @(negedge clk);
        checks++; if (uo_out !== 8'h89) begin failures++; $display("FAIL dither_fc2 got=%h exp=89", uo_out); end
    endtask

    task automatic test_mode_switch();
        reset_dut(1'b0);
        r_in = 4'hA;
        g_in = 4'h5;
        b_in = 4'hC;
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (uo_out !== 8'hED) begin failures++; $display("FAIL pre_bnd_uo cyc=%0d got=%h exp=ED", i, uo_out); end
            checks++; if (uio_oe !== 8'h00) begin failures++; $display("FAIL pre_bnd_oe cyc=%0d got=%h exp=00", i, uio_oe); end
        end
        vsync_in = 1'b0;
        @(negedge clk);
        checks++; if (uo_out !== 8'hA5) begin failures++; $display("FAIL bnd_uo got=%h exp=A5", uo_out); end
        checks++; if (uio_out !== 8'hC8) begin failures++; $display("FAIL bnd_uio got=%h exp=C8", uio_out); end
        checks++; if (uio_oe !== 8'hFF) begin failures++; $display("FAIL bnd_oe got=%h exp=FF", uio_oe); end
        vsync_in = 1'b1;
        @(negedge clk);
        checks++; if (uio_out !== 8'hCC) begin failures++; $display("FAIL post_bnd_uio got=%h exp=CC", uio_out); end
    endtask

    task automatic test_random_pixels();
        reset_dut(1'($urandom));
        for (int i = 0; i < 600; i++) begin
            hsync_in = 1'($urandom);
            if ($urandom_range(0, 3) == 0) vsync_in = ~vsync_in;
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            dither_en = 1'($urandom);
            r_in  = 4'($urandom);
            g_in  = 4'($urandom);
            b_in  = 4'($urandom);
            x_lsb = 1'($urandom);
            y_lsb = 1'($urandom);
            @(negedge clk);
            checks++; if (uo_out !== exp_uo) begin failures++; $display("FAIL rand_uo cyc=%0d got=%h exp=%h", i, uo_out, exp_uo); end
            checks++; if (uio_out !== exp_uio) begin failures++; $display("FAIL rand_uio cyc=%0d got=%h exp=%h", i, uio_out, exp_uio); end
            checks++; if (uio_oe !== exp_oe) begin failures++; $display("FAIL rand_oe cyc=%0d got=%h exp=%h", i, uio_oe, exp_oe); end
        end
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 2; m++) begin
            reset_dut(1'(m));
            dither_en = 1'b0;
            for (int i = 0; i < 40; i++) begin
                hsync_in = ~hsync_in;
                vsync_in = 1'(i % 3 != 0);
                r_in = 4'($urandom);
                g_in = 4'($urandom);
                b_in = 4'($urandom);
                @(negedge clk);
                checks++; if (uo_out !== exp_uo) begin failures++; $display("FAIL b2b_uo mode=%0d cyc=%0d got=%h exp=%h", m, i, uo_out, exp_uo); end
                checks++; if (uio_out !== exp_uio) begin failures++; $display("FAIL b2b_uio mode=%0d cyc=%0d got=%h exp=%h", m, i, uio_out, exp_uio); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_random_buttons();
        test_dither();
        test_mode_switch();
        test_random_pixels();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
